// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry defaults, palette and RGB332 helpers
package tetris_pkg;

  localparam int DEF_NUM_CELLS_X = 10;
  localparam int DEF_NUM_CELLS_Y = 20;

  // Counter widths cover CELL_SIZE up to 32 and a cell index saturating at 32.
  localparam int SUB_W  = 5;
  localparam int CELL_W = 6;

  localparam logic [7:0] GRID_RGB = 8'h24;
  localparam logic [7:0] PALETTE [0:7] = '{8'h00, 8'h13, 8'h92, 8'h38,
                                           8'h38, 8'h39, 8'h38, 8'h39};

  function automatic logic [2:0] rgb332_r(input logic [7:0] c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] rgb332_g(input logic [7:0] c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] rgb332_b(input logic [7:0] c);
    return c[1:0];
  endfunction

endpackage

// File: rtl/tetris_board_renderer_if.sv
// rtl/tetris_board_renderer_if.sv - cell query bus between the renderer and tetris_engine
interface tetris_board_renderer_if;
  logic [7:0] query_pos;
  logic [2:0] query_res;

  modport master (output query_pos, input query_res);
  modport slave  (input query_pos, output query_res);
endinterface

// File: rtl/tetris_cell_axis.sv
// rtl/tetris_cell_axis.sv - per-axis cell/sub-pixel counter, no division
// Outputs are the position of the current pixel (next-state view of the counters).
module tetris_cell_axis
  import tetris_pkg::*;
#(
  parameter int START     = 0,
  parameter int CELL_SIZE = 16,
  parameter int NUM_CELLS = 10,
  parameter int POS_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_i,
  input  logic [POS_W-1:0]  pos_i,
  output logic [SUB_W-1:0]  sub_o,
  output logic [CELL_W-1:0] cell_o,
  output logic              in_range_o
);

  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [CELL_W-1:0] cell_q, cell_d;

  always_comb begin
    sub_d  = sub_q;
    cell_d = cell_q;
    if (step_i) begin
      if (int'(pos_i) == START) begin
        sub_d  = '0;
        cell_d = '0;
      end else if (int'(sub_q) == CELL_SIZE - 1) begin
        sub_d = '0;
        if (int'(cell_q) < NUM_CELLS) cell_d = cell_q + CELL_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q  <= '0;
      cell_q <= '0;
    end else if (step_i) begin
      sub_q  <= sub_d;
      cell_q <= cell_d;
    end
  end

  assign sub_o      = sub_d;
  assign cell_o     = cell_d;
  assign in_range_o = (int'(pos_i) >= START) && (int'(pos_i) < START + NUM_CELLS * CELL_SIZE);

endmodule

// File: rtl/tetris_board_renderer.sv
// rtl/tetris_board_renderer.sv - two-stage board pixel pipeline between timing generator and VGA pins
// S0 registers region flags and issues the cell query; S1 resolves colour from query_res.
module tetris_board_renderer
  import tetris_pkg::*;
#(
  parameter int   NUM_CELLS_X = DEF_NUM_CELLS_X,
  parameter int   NUM_CELLS_Y = DEF_NUM_CELLS_Y,
  parameter int   CELL_SIZE   = 16,
  parameter int   BOARD_X0    = 240,
  parameter int   BOARD_Y0    = 40,
  parameter int   BORDER      = 10,
  parameter int   GRID_LINES  = 1,
  parameter int   BLINK_BIT   = 4,
  parameter logic SYNC_IDLE   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_stb,
  input  logic [9:0]             in_x,
  input  logic [8:0]             in_y,
  input  logic                   in_active,
  input  logic                   in_hs,
  input  logic                   in_vs,
  tetris_board_renderer_if.master qry,
  input  logic [NUM_CELLS_Y-1:0] blink_row_mask,
  input  logic [7:0]             border_rgb,
  output logic [2:0]             VGA_R,
  output logic [2:0]             VGA_G,
  output logic [1:0]             VGA_B,
  output logic                   hsync,
  output logic                   vsync
);

  localparam int BX1 = BOARD_X0 + NUM_CELLS_X * CELL_SIZE;
  localparam int BY1 = BOARD_Y0 + NUM_CELLS_Y * CELL_SIZE;

  logic [SUB_W-1:0]  sub_x, sub_y;
  logic [CELL_W-1:0] col, ycell, row;
  logic              in_bx, in_by;

  tetris_cell_axis #(
    .START(BOARD_X0), .CELL_SIZE(CELL_SIZE), .NUM_CELLS(NUM_CELLS_X), .POS_W(10)
  ) u_axis_x (
    .clk(clk), .reset(reset), .step_i(pix_stb), .pos_i(in_x),
    .sub_o(sub_x), .cell_o(col), .in_range_o(in_bx)
  );

  tetris_cell_axis #(
    .START(BOARD_Y0), .CELL_SIZE(CELL_SIZE), .NUM_CELLS(NUM_CELLS_Y), .POS_W(9)
  ) u_axis_y (
    .clk(clk), .reset(reset), .step_i(pix_stb && in_x == '0), .pos_i(in_y),
    .sub_o(sub_y), .cell_o(ycell), .in_range_o(in_by)
  );

  logic       board_d, border_d, blink_d;
  logic [7:0] query_pos_d;

  always_comb begin
    board_d  = in_bx && in_by;
    border_d = !board_d
               && int'(in_x) >= BOARD_X0 - BORDER && int'(in_x) < BX1 + BORDER
               && int'(in_y) >= BOARD_Y0 - BORDER && int'(in_y) < BY1 + BORDER;
    row         = CELL_W'(NUM_CELLS_Y - 1) - ycell;
    query_pos_d = 8'(int'(row) * NUM_CELLS_X + int'(col));
    blink_d     = 1'b0;
    for (int r = 0; r < NUM_CELLS_Y; r++) begin
      if (int'(row) == r) blink_d = board_d && blink_row_mask[r];
    end
  end

  logic       board_q, border_q, active_q, grid_q, blink_q, hs_q, vs_q;
  logic       vs_prev_q, frame_ok_q, hsync_q, vsync_q;
  logic [7:0] query_pos_q, frame_cnt_q, color_q, color_d;

  always_comb begin
    color_d = 8'h00;
    if (!active_q || !frame_ok_q)                                   color_d = 8'h00;
    else if (border_q)                                               color_d = border_rgb;
    else if (board_q && blink_q && frame_cnt_q[BLINK_BIT])           color_d = 8'hFF;
    else if (board_q && GRID_LINES != 0 && grid_q && qry.query_res == 3'd0) color_d = GRID_RGB;
    else if (board_q)                                                color_d = PALETTE[qry.query_res];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q     <= 1'b0;
      border_q    <= 1'b0;
      active_q    <= 1'b0;
      grid_q      <= 1'b0;
      blink_q     <= 1'b0;
      hs_q        <= SYNC_IDLE;
      vs_q        <= SYNC_IDLE;
      vs_prev_q   <= SYNC_IDLE;
      frame_ok_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
      query_pos_q <= 8'd0;
      color_q     <= 8'd0;
      hsync_q     <= SYNC_IDLE;
      vsync_q     <= SYNC_IDLE;
    end else if (pix_stb) begin
      board_q   <= board_d;
      border_q  <= border_d;
      active_q  <= in_active;
      grid_q    <= (sub_x == '0) || (sub_y == '0);
      blink_q   <= blink_d;
      hs_q      <= in_hs;
      vs_q      <= in_vs;
      vs_prev_q <= in_vs;
      if (board_d) query_pos_q <= query_pos_d;
      // frame_ok only ever sets here, so a mid-frame reset blanks until the next vsync.
      if (in_vs != SYNC_IDLE && vs_prev_q == SYNC_IDLE) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        frame_ok_q  <= 1'b1;
      end
      color_q <= color_d;
      hsync_q <= hs_q;
      vsync_q <= vs_q;
    end
  end

  assign qry.query_pos = query_pos_q;
  assign VGA_R = rgb332_r(color_q);
  assign VGA_G = rgb332_g(color_q);
  assign VGA_B = rgb332_b(color_q);
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// tb/tb_tetris_board_renderer.sv - directed bench for tetris_board_renderer
// u0 uses the default geometry, u1 a 4-wide board of 12-pixel cells.
module tb_tetris_board_renderer;
  import tetris_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_stb = 1'b0;
  logic [9:0]  in_x = '0;
  logic [8:0]  in_y = '0;
  logic        in_active = 1'b0;
  logic        in_hs = 1'b1;
  logic        in_vs = 1'b1;
  logic [2:0]  res = 3'd0;
  logic [19:0] mask = '0;
  logic [7:0]  border_rgb = 8'hE0;

  logic [2:0] r0, g0, r1, g1;
  logic [1:0] b0, b1;
  logic       hs0, vs0, hs1, vs1;
  logic [7:0] rgb0, rgb1, qpos0, qpos1;

  int errors = 0;
  int checks = 0;

  tetris_board_renderer_if if0();
  tetris_board_renderer_if if1();
  assign if0.query_res = res;
  assign if1.query_res = res;
  assign rgb0  = {r0, g0, b0};
  assign rgb1  = {r1, g1, b1};
  assign qpos0 = if0.query_pos;
  assign qpos1 = if1.query_pos;

  tetris_board_renderer u0 (
    .clk(clk), .reset(reset), .pix_stb(pix_stb), .in_x(in_x), .in_y(in_y),
    .in_active(in_active), .in_hs(in_hs), .in_vs(in_vs), .qry(if0),
    .blink_row_mask(mask), .border_rgb(border_rgb),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .hsync(hs0), .vsync(vs0)
  );

  tetris_board_renderer #(.NUM_CELLS_X(4), .CELL_SIZE(12)) u1 (
    .clk(clk), .reset(reset), .pix_stb(pix_stb), .in_x(in_x), .in_y(in_y),
    .in_active(in_active), .in_hs(in_hs), .in_vs(in_vs), .qry(if1),
    .blink_row_mask(mask), .border_rgb(border_rgb),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .hsync(hs1), .vsync(vs1)
  );

  always #5 clk = ~clk;

  task automatic strobe(input int x, input int y, input logic hs = 1'b1, input logic vs = 1'b1);
    in_x      = 10'(x);
    in_y      = 9'(y);
    in_active = (x < 640) && (y < 400);
    in_hs     = hs;
    in_vs     = vs;
    pix_stb   = 1'b1;
    @(posedge clk);
    #1;
    pix_stb = 1'b0;
  endtask

  task automatic vsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      strobe(1, 0, 1'b1, 1'b0);
      strobe(1, 0);
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    checks++; if (rgb0 !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h want 00", rgb0); end
    checks++; if (hs0 !== 1'b1 || vs0 !== 1'b1) begin errors++; $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hs0, vs0); end
    checks++; if (qpos0 !== 8'd0) begin errors++; $display("FAIL reset_qpos: got %0d want 0", qpos0); end
    strobe(240, 40, 1'b0, 1'b0);
    checks++; if (rgb0 !== 8'h00 || qpos0 !== 8'd0 || hs0 !== 1'b1) begin
      errors++; $display("FAIL reset_wins: got rgb=%h qpos=%0d hs=%b want 00 0 1", rgb0, qpos0, hs0);
    end
    reset = 1'b0;
  endtask

  task automatic test_frame_gate;
    res = 3'd1;
    strobe(0, 40);
    strobe(240, 40);
    checks++; if (qpos0 !== 8'd190) begin errors++; $display("FAIL gate_qpos: got %0d want 190", qpos0); end
    strobe(241, 40);
    checks++; if (rgb0 !== 8'h00) begin errors++; $display("FAIL gate_blank: got %h want 00", rgb0); end
    vsync_pulses(1);
  endtask

  task automatic test_first_pixel;
    res = 3'd1;
    strobe(0, 40);
    strobe(240, 40);
    checks++; if (qpos0 !== 8'd190) begin errors++; $display("FAIL first_qpos: got %0d want 190", qpos0); end
    strobe(241, 40);
    checks++; if (r0 !== 3'd0 || g0 !== 3'd4 || b0 !== 2'd3) begin
      errors++; $display("FAIL first_rgb: got %h want 13", rgb0);
    end
  endtask

  task automatic test_columns;
    res = 3'd0;
    strobe(0, 41);
    for (int x = 225; x <= 411; x++) begin
      strobe(x, 41);
      case (x)
        230: begin checks++; if (rgb0 !== 8'h00) begin errors++; $display("FAIL px229_outside: got %h want 00", rgb0); end end
        240: begin checks++; if (rgb0 !== 8'hE0) begin errors++; $display("FAIL px239_border: got %h want e0", rgb0); end end
        251: begin checks++; if (qpos1 !== 8'd76) begin errors++; $display("FAIL cs12_x251: got %0d want 76", qpos1); end end
        252: begin checks++; if (qpos1 !== 8'd77) begin errors++; $display("FAIL cs12_x252: got %0d want 77", qpos1); end end
        255: begin checks++; if (qpos0 !== 8'd190) begin errors++; $display("FAIL x255_col0: got %0d want 190", qpos0); end end
        256: begin
          checks++; if (qpos0 !== 8'd191) begin errors++; $display("FAIL x256_col1: got %0d want 191", qpos0); end
          checks++; if (rgb0 !== 8'h00) begin errors++; $display("FAIL px255_sub15: got %h want 00", rgb0); end
        end
        257: begin checks++; if (rgb0 !== 8'h24) begin errors++; $display("FAIL px256_grid: got %h want 24", rgb0); end end
        263: begin checks++; if (qpos1 !== 8'd77) begin errors++; $display("FAIL cs12_x263: got %0d want 77", qpos1); end end
        264: begin checks++; if (qpos1 !== 8'd78) begin errors++; $display("FAIL cs12_x264: got %0d want 78", qpos1); end end
        265: begin checks++; if (rgb1 !== 8'h24) begin errors++; $display("FAIL cs12_px264_grid: got %h want 24", rgb1); end end
        276: begin checks++; if (qpos1 !== 8'd79) begin errors++; $display("FAIL cs12_x276: got %0d want 79", qpos1); end end
        288: begin
          checks++; if (qpos1 !== 8'd79) begin errors++; $display("FAIL cs12_x288_hold: got %0d want 79", qpos1); end
          checks++; if (rgb1 !== 8'h00) begin errors++; $display("FAIL cs12_px287: got %h want 00", rgb1); end
        end
        289: begin checks++; if (rgb1 !== 8'hE0) begin errors++; $display("FAIL cs12_px288_border: got %h want e0", rgb1); end end
        399: begin checks++; if (qpos0 !== 8'd199) begin errors++; $display("FAIL x399_col9: got %0d want 199", qpos0); end end
        400: begin checks++; if (qpos0 !== 8'd199) begin errors++; $display("FAIL x400_hold: got %0d want 199", qpos0); end end
        401: begin checks++; if (rgb0 !== 8'hE0) begin errors++; $display("FAIL px400_border: got %h want e0", rgb0); end end
        411: begin checks++; if (rgb0 !== 8'h00) begin errors++; $display("FAIL px410_outside: got %h want 00", rgb0); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_row_mapping;
    for (int y = 42; y <= 359; y++) strobe(0, y);
    res = 3'd3;
    strobe(240, 359);
    checks++; if (qpos0 !== 8'd0) begin errors++; $display("FAIL bottom_row_qpos: got %0d want 0", qpos0); end
    strobe(241, 359);
    checks++; if (rgb0 !== 8'h38) begin errors++; $display("FAIL bottom_row_rgb: got %h want 38", rgb0); end
  endtask

  task automatic test_blink;
    int         pulses [5] = '{0, 15, 0, 0, 16};
    logic [19:0] masks [5] = '{20'h00001, 20'h00001, 20'h00002, 20'h80000, 20'h00001};
    logic [7:0]  expect_rgb [5] = '{8'h38, 8'hFF, 8'h38, 8'h38, 8'h38};
    res = 3'd3;
    for (int i = 0; i < 5; i++) begin
      vsync_pulses(pulses[i]);
      mask = masks[i];
      strobe(240, 359);
      strobe(241, 359);
      checks++; if (rgb0 !== expect_rgb[i]) begin
        errors++; $display("FAIL blink_%0d: got %h want %h", i, rgb0, expect_rgb[i]);
      end
    end
    mask = '0;
  endtask

  task automatic test_bottom_border;
    strobe(0, 360);
    strobe(240, 360);
    checks++; if (qpos0 !== 8'd0) begin errors++; $display("FAIL y360_hold: got %0d want 0", qpos0); end
    strobe(241, 360);
    checks++; if (rgb0 !== 8'hE0) begin errors++; $display("FAIL y360_border: got %h want e0", rgb0); end
  endtask

  task automatic test_stall;
    in_hs = 1'b0;
    in_x  = 10'd5;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rgb0 !== 8'hE0 || hs0 !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got rgb=%h hs=%b want e0 1", rgb0, hs0);
    end
    strobe(242, 360, 1'b0);
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL hs_lat1: got %b want 1", hs0); end
    strobe(243, 360, 1'b0);
    checks++; if (hs0 !== 1'b0) begin errors++; $display("FAIL hs_lat2: got %b want 0", hs0); end
  endtask

  task automatic test_reset_mid_line;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rgb0 !== 8'h00 || hs0 !== 1'b1 || vs0 !== 1'b1 || qpos0 !== 8'd0) begin
      errors++; $display("FAIL async_reset: got rgb=%h hs=%b vs=%b qpos=%0d want 00 1 1 0", rgb0, hs0, vs0, qpos0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    res = 3'd2;
    strobe(0, 40);
    strobe(240, 40);
    strobe(241, 40);
    checks++; if (rgb0 !== 8'h00) begin errors++; $display("FAIL post_reset_blank: got %h want 00", rgb0); end
    vsync_pulses(1);
    strobe(0, 40);
    strobe(240, 40);
    strobe(241, 40);
    checks++; if (rgb0 !== 8'h92) begin errors++; $display("FAIL post_vsync_rgb: got %h want 92", rgb0); end
  endtask

  initial begin
    test_reset();
    test_frame_gate();
    test_first_pixel();
    test_columns();
    test_row_mapping();
    test_blink();
    test_bottom_border();
    test_stall();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
